// File: rtl/triangle_cull_fifo.sv
// triangle_cull_fifo
//
// Sits behind the projector. For each strobed triangle it computes a screen
// bounding box and a doubled signed area. It discards triangles that are off
// screen or have zero area. Surviving triangles are buffered, together with
// their clamped bbox, for the rasterizer. The projector cannot be stalled, so
// a push into a full buffer is dropped and counted.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   triangle_in       160-bit screen-space triangle word
//   new_triangle_in   one-cycle strobe qualifying triangle_in
//   done_in           one-cycle pulse: projector has issued the whole frame
//   tri_out/bbox_out  head entry of the buffer; zero while the buffer is empty
//   tri_valid         buffer non-empty
//   tri_ready         consumer takes the head when tri_valid && tri_ready
//   done_out          one-cycle pulse when the frame has fully drained
//   culled_count      saturating count of culled triangles
//   dropped_count     saturating count of triangles lost to a full buffer
//   overflow          sticky, set on the first drop
//
// Done FSM
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | frame in progress (or none); waits for done_in
//   ST_DRAIN | done seen; waits for the pipeline and buffer to empty, and
//            | pulses done_out in the first cycle both are empty

module triangle_cull_fifo #(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720,
    parameter int DEPTH  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [159:0] triangle_in,
    input  logic         new_triangle_in,
    input  logic         done_in,
    output logic [159:0] tri_out,
    output logic [63:0]  bbox_out,
    output logic         tri_valid,
    input  logic         tri_ready,
    output logic         done_out,
    output logic [15:0]  culled_count,
    output logic [15:0]  dropped_count,
    output logic         overflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic signed [15:0] W_S    = 16'(WIDTH);
    localparam logic signed [15:0] H_S    = 16'(HEIGHT);
    localparam logic signed [15:0] XLAST  = 16'(WIDTH - 1);
    localparam logic signed [15:0] YLAST  = 16'(HEIGHT - 1);
    localparam logic [AW-1:0]      PTR_ONE = 1;
    localparam logic [AW:0]        CNT_ONE = 1;
    localparam logic [AW:0]        CNT_FULL = (AW+1)'(DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    function automatic logic signed [15:0] min3(input logic signed [15:0] a,
                                                input logic signed [15:0] b,
                                                input logic signed [15:0] c);
        logic signed [15:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [15:0] max3(input logic signed [15:0] a,
                                                input logic signed [15:0] b,
                                                input logic signed [15:0] c);
        logic signed [15:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: bbox extremes and edge vectors relative to p1
    // ------------------------------------------------------------------
    logic signed [15:0] p1x, p1y, p2x, p2y, p3x, p3y;
    logic signed [16:0] dx1_d, dy1_d, dx2_d, dy2_d;

    assign p1x = triangle_in[143:128];
    assign p1y = triangle_in[127:112];
    assign p2x = triangle_in[111:96];
    assign p2y = triangle_in[95:80];
    assign p3x = triangle_in[79:64];
    assign p3y = triangle_in[63:48];

    // Sign-extend by hand so the 17-bit differences never wrap.
    assign dx1_d = {p2x[15], p2x} - {p1x[15], p1x};
    assign dy1_d = {p2y[15], p2y} - {p1y[15], p1y};
    assign dx2_d = {p3x[15], p3x} - {p1x[15], p1x};
    assign dy2_d = {p3y[15], p3y} - {p1y[15], p1y};

    logic               s1_valid_q;
    logic [159:0]       s1_word_q;
    logic signed [15:0] s1_xmin_q, s1_xmax_q, s1_ymin_q, s1_ymax_q;
    logic signed [16:0] s1_dx1_q, s1_dy1_q, s1_dx2_q, s1_dy2_q;

    always_ff @(posedge clk) begin
        if (rst) s1_valid_q <= 1'b0;
        else     s1_valid_q <= new_triangle_in;
    end

    always_ff @(posedge clk) begin
        if (new_triangle_in) begin
            s1_word_q <= triangle_in;
            s1_xmin_q <= min3(p1x, p2x, p3x);
            s1_xmax_q <= max3(p1x, p2x, p3x);
            s1_ymin_q <= min3(p1y, p2y, p3y);
            s1_ymax_q <= max3(p1y, p2y, p3y);
            s1_dx1_q  <= dx1_d;
            s1_dy1_q  <= dy1_d;
            s1_dx2_q  <= dx2_d;
            s1_dy2_q  <= dy2_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: area, cull decision, clamp
    // ------------------------------------------------------------------
    logic signed [34:0] prod_a, prod_b, area2;
    logic               reject;
    logic               s2_keep_d, s2_cull_d;
    logic signed [15:0] cx_min, cy_min, cx_max, cy_max;

    assign prod_a = s1_dx1_q * s1_dy2_q;
    assign prod_b = s1_dx2_q * s1_dy1_q;
    assign area2  = prod_a - prod_b;

    assign reject = (s1_xmax_q < 16'sd0) || (s1_ymax_q < 16'sd0) ||
                    (s1_xmin_q >= W_S)   || (s1_ymin_q >= H_S)   ||
                    (area2 == 35'sd0);

    assign s2_keep_d = s1_valid_q && !reject;
    assign s2_cull_d = s1_valid_q && reject;

    // Survivors already satisfy xmax>=0 and xmin<WIDTH, so one-sided clamps suffice.
    assign cx_min = (s1_xmin_q < 16'sd0) ? 16'sd0 : s1_xmin_q;
    assign cy_min = (s1_ymin_q < 16'sd0) ? 16'sd0 : s1_ymin_q;
    assign cx_max = (s1_xmax_q > XLAST)  ? XLAST  : s1_xmax_q;
    assign cy_max = (s1_ymax_q > YLAST)  ? YLAST  : s1_ymax_q;

    logic         s2_keep_q, s2_cull_q;
    logic [159:0] s2_word_q;
    logic [63:0]  s2_bbox_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_keep_q <= 1'b0;
            s2_cull_q <= 1'b0;
        end else begin
            s2_keep_q <= s2_keep_d;
            s2_cull_q <= s2_cull_d;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            s2_word_q <= s1_word_q;
            s2_bbox_q <= {cx_min, cy_min, cx_max, cy_max};
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: survivor buffer
    // ------------------------------------------------------------------
    logic [223:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full, push, pop, wr_en, drop;
    logic [223:0]  head;

    assign full  = (count_q == CNT_FULL);
    assign push  = s2_keep_q;
    assign pop   = tri_valid && tri_ready;
    // When full, the popped slot is the one written, so a same-cycle pop frees it.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {s2_word_q, s2_bbox_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (wr_en && !pop)      count_q <= count_q + CNT_ONE;
            else if (!wr_en && pop) count_q <= count_q - CNT_ONE;
        end
    end

    assign tri_valid = (count_q != '0);
    assign head      = mem_q[rd_ptr_q];
    // Gate so the uninitialised storage never shows on the outputs.
    assign tri_out   = tri_valid ? head[223:64] : '0;
    assign bbox_out  = tri_valid ? head[63:0]   : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            culled_count  <= '0;
            dropped_count <= '0;
            overflow      <= 1'b0;
        end else begin
            if (s2_cull_q && culled_count != 16'hFFFF)
                culled_count <= culled_count + 16'd1;
            if (drop && dropped_count != 16'hFFFF)
                dropped_count <= dropped_count + 16'd1;
            if (drop)
                overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Done FSM
    // ------------------------------------------------------------------
    logic [0:0] state_q, state_d;
    logic       drained;

    assign drained  = !s1_valid_q && !s2_keep_q && !s2_cull_q && (count_q == '0);
    assign done_out = (state_q == ST_DRAIN) && drained;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (done_in) state_d = ST_DRAIN;
            ST_DRAIN: if (drained) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

endmodule

// File: tb/tb_triangle_cull_fifo.sv
module tb_triangle_cull_fifo;

    logic         clk = 1'b0;
    logic         rst;
    logic [159:0] triangle_in;
    logic         new_triangle_in;
    logic         done_in;
    logic [159:0] tri_out;
    logic [63:0]  bbox_out;
    logic         tri_valid;
    logic         tri_ready;
    logic         done_out;
    logic [15:0]  culled_count;
    logic [15:0]  dropped_count;
    logic         overflow;

    triangle_cull_fifo #(.WIDTH(1280), .HEIGHT(720), .DEPTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .triangle_in     (triangle_in),
        .new_triangle_in (new_triangle_in),
        .done_in         (done_in),
        .tri_out         (tri_out),
        .bbox_out        (bbox_out),
        .tri_valid       (tri_valid),
        .tri_ready       (tri_ready),
        .done_out        (done_out),
        .culled_count    (culled_count),
        .dropped_count   (dropped_count),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int pop_cnt = 0;
    logic [223:0] exp_q[$];

    task automatic chk(input string tag, input logic [223:0] got, input logic [223:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: {keep, xmin, ymin, xmax, ymax}
    function automatic logic [64:0] model(input int x1, input int y1, input int x2,
                                          input int y2, input int x3, input int y3);
        int xmin, xmax, ymin, ymax;
        longint a;
        bit keep;
        xmin = x1; if (x2 < xmin) xmin = x2; if (x3 < xmin) xmin = x3;
        xmax = x1; if (x2 > xmax) xmax = x2; if (x3 > xmax) xmax = x3;
        ymin = y1; if (y2 < ymin) ymin = y2; if (y3 < ymin) ymin = y3;
        ymax = y1; if (y2 > ymax) ymax = y2; if (y3 > ymax) ymax = y3;
        a = longint'(x2 - x1) * longint'(y3 - y1) - longint'(x3 - x1) * longint'(y2 - y1);
        keep = !(xmax < 0 || ymax < 0 || xmin >= 1280 || ymin >= 720 || a == 0);
        if (xmin < 0) xmin = 0;
        if (ymin < 0) ymin = 0;
        if (xmax > 1279) xmax = 1279;
        if (ymax > 719) ymax = 719;
        return {keep, 16'(xmin), 16'(ymin), 16'(xmax), 16'(ymax)};
    endfunction

    task automatic send(input int x1, input int y1, input int x2, input int y2,
                        input int x3, input int y3, input bit drop, input bit with_done);
        logic [159:0] w;
        logic [64:0]  m;
        w = {16'($urandom), 16'(x1), 16'(y1), 16'(x2), 16'(y2), 16'(x3), 16'(y3),
             24'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        m = model(x1, y1, x2, y2, x3, y3);
        @(posedge clk); #1;
        triangle_in     = w;
        new_triangle_in = 1'b1;
        done_in         = with_done;
        if (m[64] && !drop) exp_q.push_back({w, m[63:0]});
    endtask

    task automatic idle();
        @(posedge clk); #1;
        new_triangle_in = 1'b0;
        done_in         = 1'b0;
    endtask

    task automatic wait_empty(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || tri_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {223'd0, (exp_q.size() == 0 && !tri_valid)}, 224'd1);
    endtask

    // Scoreboard: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (tri_valid && tri_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) chk("unexp_pop", 224'd1, 224'd0);
            else chk("pop_data", {tri_out, bbox_out}, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    initial begin
        int base, pulses, first_done, first_empty;
        logic seen;

        rst = 1'b1; triangle_in = '0; new_triangle_in = 1'b0; done_in = 1'b0; tri_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",   {223'd0, tri_valid}, 224'd0);
        chk("rst_done",    {223'd0, done_out}, 224'd0);
        chk("rst_culled",  {208'd0, culled_count}, 224'd0);
        chk("rst_dropped", {208'd0, dropped_count}, 224'd0);
        chk("rst_ovf",     {223'd0, overflow}, 224'd0);
        chk("rst_data",    {tri_out, bbox_out}, 224'd0);
        @(posedge clk); #1; rst = 1'b0; tri_ready = 1'b1;

        // Single triangle: latency, bbox, single-cycle valid
        send(100, 100, 200, 100, 100, 200, 1'b0, 1'b0);
        @(negedge clk); chk("lat_n0", {223'd0, tri_valid}, 224'd0);
        idle();
        @(negedge clk); chk("lat_n1", {223'd0, tri_valid}, 224'd0);
        @(negedge clk); chk("lat_n2", {223'd0, tri_valid}, 224'd0);
        @(negedge clk); chk("lat_n3", {223'd0, tri_valid}, 224'd1);
        chk("single_bbox", {160'd0, bbox_out}, {160'd0, 64'h0064_0064_00C8_00C8});
        @(negedge clk); chk("lat_n4", {223'd0, tri_valid}, 224'd0);

        // Culled cases, then boundary survivors
        send(-50, 10, -10, 10, -30, 40, 1'b0, 1'b0);
        send(1300, 0, 1400, 0, 1300, 50, 1'b0, 1'b0);
        send(0, 0, 10, 10, 20, 20, 1'b0, 1'b0);
        idle();
        repeat (5) @(negedge clk);
        chk("culled3", {208'd0, culled_count}, 224'd3);
        chk("no_valid", {223'd0, tri_valid}, 224'd0);
        send(1279, 0, 1300, 0, 1279, 10, 1'b0, 1'b0);
        send(-10, 0, 0, 0, -10, 10, 1'b0, 1'b0);
        send(-20, -5, 1400, 300, 600, 900, 1'b0, 1'b0);
        idle();
        wait_empty("edge_drain", 20);
        chk("culled_edge", {208'd0, culled_count}, 224'd3);

        // Overflow: 20 back-to-back with consumer stalled
        tri_ready = 1'b0;
        for (int i = 0; i < 20; i++)
            send(10 + i, 10, 50 + i, 10, 10 + i, 60, (i >= 16), 1'b0);
        idle();
        repeat (4) @(negedge clk);
        chk("drop4", {208'd0, dropped_count}, 224'd4);
        chk("ovf1",  {223'd0, overflow}, 224'd1);
        chk("hold_head0", {tri_out, bbox_out}, exp_q[0]);
        @(negedge clk);
        chk("hold_head1", {tri_out, bbox_out}, exp_q[0]);
        base = pop_cnt;
        @(posedge clk); #1; tri_ready = 1'b1;
        wait_empty("ovf_drain", 40);
        chk("ovf_pops", {192'd0, 32'(pop_cnt - base)}, 224'd16);

        // Full FIFO with a simultaneous push and pop
        tri_ready = 1'b0;
        for (int i = 0; i < 16; i++)
            send(30, 30 + i, 90, 30 + i, 30, 80 + i, 1'b0, 1'b0);
        idle();
        repeat (4) @(negedge clk);
        send(5, 5, 15, 5, 5, 15, 1'b0, 1'b0);
        idle();
        @(posedge clk); #1; tri_ready = 1'b1;
        @(posedge clk); #1; tri_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("full_pop_drop", {208'd0, dropped_count}, 224'd4);
        base = pop_cnt;
        @(posedge clk); #1; tri_ready = 1'b1;
        wait_empty("full_drain", 40);
        chk("full_pops", {192'd0, 32'(pop_cnt - base)}, 224'd16);

        // Done with stalled consumer
        tri_ready = 1'b0;
        send(100, 50, 300, 50, 100, 250, 1'b0, 1'b0);
        send(200, 60, 400, 60, 200, 260, 1'b0, 1'b0);
        send(300, 70, 500, 70, 300, 270, 1'b0, 1'b1);
        idle();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen |= done_out;
        end
        chk("done_early", {223'd0, seen}, 224'd0);
        @(posedge clk); #1; tri_ready = 1'b1;
        pulses = 0; first_done = -1; first_empty = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_out) begin
                pulses++;
                if (first_done < 0) first_done = i;
            end
            if (!tri_valid && first_empty < 0) first_empty = i;
        end
        chk("done_pulses", {192'd0, 32'(pulses)}, 224'd1);
        chk("done_timing", {192'd0, 32'(first_done)}, {192'd0, 32'(first_empty)});
        chk("done_sb", {192'd0, 32'(exp_q.size())}, 224'd0);

        // Reset in the middle of a drain
        tri_ready = 1'b0;
        send(100, 100, 200, 100, 100, 200, 1'b0, 1'b0);
        send(110, 100, 210, 100, 110, 200, 1'b0, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        @(posedge clk); #1; rst = 1'b1; exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid",   {223'd0, tri_valid}, 224'd0);
        chk("mid_rst_culled",  {208'd0, culled_count}, 224'd0);
        chk("mid_rst_dropped", {208'd0, dropped_count}, 224'd0);
        chk("mid_rst_ovf",     {223'd0, overflow}, 224'd0);
        chk("mid_rst_data",    {tri_out, bbox_out}, 224'd0);
        @(posedge clk); #1; rst = 1'b0; tri_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen |= done_out | tri_valid;
        end
        chk("mid_rst_quiet", {223'd0, seen}, 224'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
